// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type and pipeline stall controller states.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DDONE = 2'd2,
    HALT  = 2'd3
  } stall_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_memToReg,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_uses_rt,
  output logic     hazard
);

  // $zero never carries a dependency, so a load into it cannot stall.
  assign hazard = ex_memToReg && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage datapath.
// Optional macro STALL_PERF_EN adds cycle, stall and flush performance counters.
//
// state | meaning
// RUN   | normal flow; no data access outstanding
// DWAIT | data access issued, waiting for dhit; pipeline frozen
// DDONE | data access completed, waiting for ihit; mem_done masks reissue
// HALT  | halt retired; pipeline stopped until reset
module pipe_stall_ctrl
  import cpu_types_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dREN,
  input  logic              mem_dWEN,
  input  logic              ex_memToReg,
  input  regbits_t          ex_rt,
  input  regbits_t          id_rs,
  input  regbits_t          id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jmp,
  input  logic              mem_branch_taken,
  input  logic              wb_halt,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_flush,
  output logic              mem_done,
  output logic              halted
`ifdef STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  stall_state_t state;
  logic mem_req, data_ok, adv, hazard;

  load_use_detect u_lud (
    .ex_memToReg (ex_memToReg),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hazard      (hazard)
  );

  assign mem_req = mem_dREN | mem_dWEN;
  assign data_ok = (state == DDONE) | !mem_req | dhit;
  assign adv     = ihit & data_ok & (state != HALT) & !wb_halt;

  assign mem_done = nRST & (state == DDONE);
  assign halted   = nRST & (state == HALT);

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!nRST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (adv) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (mem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (hazard) begin
        // hold PC and IF/ID, inject a bubble into ID/EX
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jmp) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else if (state != HALT && wb_halt) begin
      state <= HALT;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !dhit)      state <= DWAIT;
          else if (mem_req && !ihit) state <= DDONE;
        end
        DWAIT: begin
          if (dhit && ihit)  state <= RUN;
          else if (dhit)     state <= DDONE;
        end
        DDONE: begin
          if (ihit) state <= RUN;
        end
        default: state <= HALT;
      endcase
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALT) begin
      cyc_cnt <= cyc_cnt + PERF_W'(1);
      if (!adv || (!mem_branch_taken && hazard))
        stall_cnt <= stall_cnt + PERF_W'(1);
      if (adv && (mem_branch_taken || (!hazard && id_jmp)))
        flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS datapath.
- Produces the enable/flush pair for each of the four pipe_reg_if instances (IF/ID, ID/EX, EX/MEM, MEM/WB), plus PC enable.
- Inputs are ihit, dhit, halt, and hazard information from the stages.
- Tracks outstanding data-memory requests across cycles so an access satisfied under an instruction miss is not reissued.

Parameters:
PERF_W, 32, width of performance counters (used only with STALL_PERF_EN)

Ports:
CLK  in  1  system clock, all state on rising edge
nRST  in  1  reset; synchronous, active-low
ihit  in  1  instruction memory hit this cycle
dhit  in  1  data memory hit this cycle
mem_dREN  in  1  MEM stage holds a load
mem_dWEN  in  1  MEM stage holds a store
ex_memToReg  in  1  EX stage instruction is a load
ex_rt  in  5  EX stage load destination (regbits_t)
id_rs  in  5  ID stage source rs
id_rt  in  5  ID stage source rt
id_uses_rt  in  1  ID instruction reads rt
id_jmp  in  1  j/jal resolved in ID
mem_branch_taken  in  1  taken branch/jr resolved in MEM
wb_halt  in  1  halt instruction in WB
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enable
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  stage register clear (bubble); flush overrides en in the register
mem_done  out  1  MEM access already completed; datapath masks dREN/dWEN and holds captured load data
halted  out  1  processor halted (registered)

Behaviour:
- State (stall_state_t): RUN, DWAIT, DDONE, HALT. Reset: state=RUN.
- While nRST=0, all four flushes are 1. All enables, pc_en, mem_done, and halted are 0.
- mem_req = mem_dREN | mem_dWEN. data_ok = (state==DDONE) | !mem_req | dhit. adv = ihit & data_ok & state!=HALT & !wb_halt.
- RUN transitions:
  - mem_req & !dhit → DWAIT.
  - mem_req & dhit & !ihit → DDONE.
  - Otherwise stay.
- DWAIT transitions:
  - dhit & ihit → RUN.
  - dhit & !ihit → DDONE.
  - Otherwise stay.
  - mem_req is guaranteed held while frozen.
- DDONE: mem_done=1. ihit → RUN.
- wb_halt=1 in any non-HALT state → HALT next edge. That cycle all enables and pc_en are 0.
- HALT is absorbing until reset. halted=1; all en and pc_en are 0; flushes are 0.
- !adv (non-halt): all en=0, pc_en=0, all flush=0. The whole pipeline freezes.
- adv: all en=1, pc_en=1, then apply the first matching rule in this priority order:
  1. mem_branch_taken: ifid_flush = idex_flush = exmem_flush = 1.
  2. Load-use: ex_memToReg & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). Effect: pc_en=0, ifid_en=0, idex_flush=1.
  3. id_jmp: ifid_flush=1.
- memwb_flush is asserted only during reset.
- Reset in DWAIT/DDONE: return to RUN; pending access abandoned; mem_done=0 next cycle.
- All outputs except halted are combinational from state and inputs. Latency from dhit to advance is 0 cycles when ihit is also high.

Optional Feature:
STALL_PERF_EN
- With it, adds outputs cyc_cnt, stall_cnt, flush_cnt (each PERF_W bits, out).
- All counters are 0 on reset.
- cyc_cnt increments every non-HALT cycle.
- stall_cnt increments on !adv or load-use.
- flush_cnt increments on each mem_branch_taken or id_jmp advance.
- Counters wrap modulo 2^PERF_W and freeze in HALT.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Add stall_state_t (2-bit enum RUN, DWAIT, DDONE, HALT) to cpu_types_pkg. Use the existing regbits_t for register ports.
- One combinational sub-module, load_use_detect (inputs ex_memToReg, ex_rt, id_rs, id_rt, id_uses_rt; output hazard), instantiated once.

Test Plan:
- nRST=0 for 2 cycles with ihit=1 → all flushes 1, enables 0, halted 0. Release → RUN; with ihit=1 and no req, all en=1.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 with ihit=1 → 3 frozen cycles in DWAIT; advance on 4th; state RUN.
- mem_dWEN=1, dhit=1, ihit=0, then ihit=1 two cycles later → DDONE with mem_done=1 for 2 cycles. No second memory write; advance when ihit=1.
- ex_memToReg=1, ex_rt=8, id_rs=8, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1. Same with ex_rt=0 → no stall.
- mem_branch_taken=1 and load-use and id_jmp together with ihit=1 → only branch squash: ifid/idex/exmem flush=1, pc_en=1.
- wb_halt=1 during DWAIT → next cycle halted=1, all en 0. Stays halted while inputs toggle; nRST pulse returns to RUN.
